// File: rtl/task_3_input_arbiter_if.sv
// rtl/task_3_input_arbiter_if.sv - source/downstream/status bundle for the task-3 input arbiter
interface task_3_input_arbiter_if #(
  parameter int LEN_W = 9
);
  logic [1:0]       i_req;
  logic             i_valid0;
  logic             i_valid1;
  logic [7:0]       i_data0;
  logic [7:0]       i_data1;
  logic             i_last0;
  logic             i_last1;
  logic             o_tready0;
  logic             o_tready1;
  logic             o_tvalid;
  logic [7:0]       o_tdata;
  logic             o_tlast;
  logic             i_tready;
  logic             i_done;
  logic [1:0]       o_grant;
  logic             o_busy;
  logic [LEN_W-1:0] o_frame_len;
  logic             o_len_err;

  // Upstream sources, input stage and done generator drive the i_* side.
  modport master (
    output i_req, i_valid0, i_valid1, i_data0, i_data1, i_last0, i_last1,
    output i_tready, i_done,
    input  o_tready0, o_tready1, o_tvalid, o_tdata, o_tlast,
    input  o_grant, o_busy, o_frame_len, o_len_err
  );

  // The arbiter itself.
  modport slave (
    input  i_req, i_valid0, i_valid1, i_data0, i_data1, i_last0, i_last1,
    input  i_tready, i_done,
    output o_tready0, o_tready1, o_tvalid, o_tdata, o_tlast,
    output o_grant, o_busy, o_frame_len, o_len_err
  );
endinterface

// File: rtl/task_3_input_arbiter.sv
// rtl/task_3_input_arbiter.sv - round-robin frame arbiter with length limit in front of the input FIFO
module task_3_input_arbiter #(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  task_3_input_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_XFER      = 3'd2,
    S_DRAIN     = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_g;
  logic             r_last;
  logic [LEN_W-1:0] r_count;
  logic [1:0]       r_grant;
  logic             r_busy;
  logic [LEN_W-1:0] r_frame_len;
  logic             r_len_err;

  logic             w_src_valid;
  logic [7:0]       w_src_data;
  logic             w_src_last;
  logic             w_at_max;
  logic             w_pick;
  logic             w_beat;
  logic             w_tvalid;
  logic [7:0]       w_tdata;
  logic             w_tlast;
  logic             w_tready0;
  logic             w_tready1;

  // Granted source is muxed once and shared by every state that looks at it.
  assign w_src_valid = r_g ? bus.i_valid1 : bus.i_valid0;
  assign w_src_data  = r_g ? bus.i_data1  : bus.i_data0;
  assign w_src_last  = r_g ? bus.i_last1  : bus.i_last0;
  assign w_at_max    = (r_count == LEN_W'(MAX_LEN - 1));
  // On a tie the source that was not served last wins; a lone requester always wins.
  assign w_pick      = (bus.i_req == 2'b11) ? ~r_last : bus.i_req[1];
  assign w_beat      = w_tvalid & bus.i_tready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (bus.i_req != 2'b00) w_next = S_GRANT;
      S_GRANT:     w_next = S_XFER;
      S_XFER: begin
        if (w_beat && w_src_last)    w_next = S_WAIT_DONE;
        else if (w_beat && w_at_max) w_next = S_DRAIN;
      end
      S_DRAIN:     if (w_src_valid && w_src_last) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.i_done) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Stream outputs: zero-latency pass-through while transferring, discard while draining.
  always_comb begin
    w_tvalid  = 1'b0;
    w_tdata   = 8'h00;
    w_tlast   = 1'b0;
    w_tready0 = 1'b0;
    w_tready1 = 1'b0;
    case (r_state)
      S_XFER: begin
        w_tvalid = w_src_valid;
        w_tdata  = w_src_data;
        w_tlast  = w_src_last | w_at_max;
        if (r_g) w_tready1 = bus.i_tready;
        else     w_tready0 = bus.i_tready;
      end
      S_DRAIN: begin
        if (r_g) w_tready1 = 1'b1;
        else     w_tready0 = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant, byte counter, round-robin pointer and registered status.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_g         <= 1'b0;
      r_last      <= 1'b1;
      r_count     <= '0;
      r_grant     <= 2'b00;
      r_busy      <= 1'b0;
      r_frame_len <= '0;
      r_len_err   <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_req != 2'b00) begin
            r_g     <= w_pick;
            r_grant <= w_pick ? 2'b10 : 2'b01;
            r_busy  <= 1'b1;
          end
        end
        S_GRANT: r_count <= '0;
        S_XFER: begin
          if (w_beat) begin
            r_count <= r_count + 1'b1;
            if (w_src_last)    r_frame_len <= r_count + 1'b1;
            else if (w_at_max) r_len_err   <= 1'b1;
          end
        end
        S_DRAIN: begin
          // A truncated frame always forwarded exactly MAX_LEN bytes.
          if (w_src_valid && w_src_last) r_frame_len <= LEN_W'(MAX_LEN);
        end
        S_WAIT_DONE: begin
          if (bus.i_done) begin
            r_last  <= r_g;
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_tvalid    = w_tvalid;
  assign bus.o_tdata     = w_tdata;
  assign bus.o_tlast     = w_tlast;
  assign bus.o_tready0   = w_tready0;
  assign bus.o_tready1   = w_tready1;
  assign bus.o_grant     = r_grant;
  assign bus.o_busy      = r_busy;
  assign bus.o_frame_len = r_frame_len;
  assign bus.o_len_err   = r_len_err;

endmodule
